// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared reset values, FSM encoding and FIFO entry type for the fetch unit.
package if_fetch_unit_pkg;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} fetch_state_e;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} queue with push, pop, flush and occupancy count.
module fetch_fifo
  import if_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? 1'b0 : wr_q ^ push;
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with one outstanding imem request and a 2-entry output FIFO.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);
  fetch_state_e state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d, last_pc_q, last_pc_d;
  logic [1:0] count;
  logic push, pop, b2b, grant;
  fetch_entry_t head, push_entry;

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign push_entry = {req_pc_q, imem_rdata_i};
  assign valid_o = count != 2'd0;
  assign pop = valid_o && !stall_i;
  assign pc_o = valid_o ? head.pc : last_pc_q;
  assign instr_o = valid_o ? head.instr : NOP_INSTR;
  assign imem_addr_o = fetch_pc_q;
  assign push = state_q == S_WAIT && imem_rvalid_i && !redirect_i;
  // Back-to-back request only if the FIFO still has room once this response lands.
  assign b2b = push && (count == 2'd0 || (count == 2'd1 && pop));
  assign imem_req_o = state_q == S_REQ || b2b;
  assign grant = imem_req_o && imem_gnt_i;

  always_comb begin
    fetch_pc_d = grant ? fetch_pc_q + 64'd4 : fetch_pc_q;
    req_pc_d = grant ? fetch_pc_q : req_pc_q;
    last_pc_d = pop ? head.pc : last_pc_q;
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = count < 2'd2 ? S_REQ : S_IDLE;
      S_REQ:   state_d = grant ? S_WAIT : S_REQ;
      S_WAIT:  state_d = !imem_rvalid_i ? S_WAIT : !b2b ? S_IDLE : grant ? S_WAIT : S_REQ;
      default: state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
    endcase
    // A response still in flight after a redirect is stale and must be drained.
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[63:2], 2'b00};
      state_d = (grant || ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid_i)) ? S_DRAIN : S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      last_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      last_pc_q <= last_pc_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch scenarios checked against a queue-based model every cycle.
module tb_if_fetch_unit;
  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
  logic imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic [31:0] imem_rdata_i = '0;
  logic imem_req_o, valid_o;
  logic [63:0] imem_addr_o, pc_o;
  logic [31:0] instr_o;
  int tests = 0, fails = 0;
  typedef struct {logic [63:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {logic [63:0] pc; bit stale;} out_t;
  ent_t q[$];
  out_t outs[$];
  ent_t e_n;
  out_t o_n;
  logic [63:0] m_pc = RPC, last_pc = RPC;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of delivered entries, outstanding requests tagged stale on redirect.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      outs.delete();
      m_pc = RPC;
      last_pc = RPC;
      chk("m_rst_req", imem_req_o, 0);
      chk("m_rst_valid", valid_o, 0);
    end else begin
      chk("m_valid", valid_o, q.size() != 0);
      chk("m_pc", pc_o, q.size() != 0 ? q[0].pc : last_pc);
      chk("m_instr", instr_o, q.size() != 0 ? q[0].instr : NOP);
      if (imem_req_o) chk("m_addr", imem_addr_o, m_pc);
      if (q.size() != 0 && !stall_i) begin
        last_pc = q[0].pc;
        void'(q.pop_front());
      end
      if (imem_rvalid_i && outs.size() != 0) begin
        o_n = outs.pop_front();
        if (!o_n.stale && !redirect_i) begin
          e_n.pc = o_n.pc;
          e_n.instr = imem_rdata_i;
          q.push_back(e_n);
        end
      end
      if (imem_req_o && imem_gnt_i) begin
        o_n.pc = m_pc;
        o_n.stale = redirect_i;
        outs.push_back(o_n);
        m_pc = m_pc + 64'd4;
      end
      if (redirect_i) begin
        q.delete();
        foreach (outs[i]) outs[i].stale = 1'b1;
        m_pc = {redirect_pc_i[63:2], 2'b00};
      end
    end
  end

  task automatic cyc(input logic g = 1'b0, input logic rv = 1'b0, input logic [31:0] rd = '0,
                     input logic st = 1'b0, input logic rdr = 1'b0, input logic [63:0] rpc = '0,
                     input logic rn = 1'b1);
    @(posedge clk);
    #1;
    rst_n = rn;
    imem_gnt_i = g;
    imem_rvalid_i = rv;
    imem_rdata_i = rd;
    stall_i = st;
    redirect_i = rdr;
    redirect_pc_i = rpc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    {imem_gnt_i, imem_rvalid_i, stall_i, redirect_i} = '0;
    @(negedge clk);
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_pc", pc_o, RPC);
    chk("rst_instr", instr_o, NOP);
    @(negedge clk);
  endtask

  task automatic chk_req(input string name, input logic [63:0] addr);
    chk({name, "_req"}, imem_req_o, 1);
    chk({name, "_addr"}, imem_addr_o, addr);
  endtask

  initial begin
    // Streaming: immediate grant, response one cycle later.
    do_reset();
    cyc(1); chk("a0_req", imem_req_o, 0);
    cyc(1); chk_req("a1", 64'h8000_0000);
    cyc(1, 1, 32'h1111_0000); chk_req("a2", 64'h8000_0004);
    cyc(1, 1, 32'h1111_0004); chk_req("a3", 64'h8000_0008);
    chk("a3_valid", valid_o, 1); chk("a3_pc", pc_o, 64'h8000_0000); chk("a3_instr", instr_o, 32'h1111_0000);
    cyc(0, 1, 32'h1111_0008); chk("a4_pc", pc_o, 64'h8000_0004); chk("a4_instr", instr_o, 32'h1111_0004);
    cyc(0); chk("a5_valid", valid_o, 1); chk("a5_pc", pc_o, 64'h8000_0008);
    // Stall fills the FIFO and suppresses requests.
    do_reset();
    cyc(1); cyc(1);
    cyc(1, 1, 32'h2222_0000, 1);
    cyc(0, 1, 32'h2222_0004, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      chk("b_hold_req", imem_req_o, 0); chk("b_hold_pc", pc_o, 64'h8000_0000); chk("b_hold_instr", instr_o, 32'h2222_0000);
    end
    cyc(0); chk("b7_pc", pc_o, 64'h8000_0000);
    cyc(0); chk("b8_pc", pc_o, 64'h8000_0004); chk("b8_instr", instr_o, 32'h2222_0004);
    cyc(0); chk("b9_valid", valid_o, 0); chk("b9_pc", pc_o, 64'h8000_0004); chk("b9_instr", instr_o, NOP);
    chk_req("b9", 64'h8000_0008);
    // Redirect while a request is outstanding: drain the stale response.
    do_reset();
    cyc(1); cyc(1);
    cyc(0, 0, 0, 0, 1, 64'h8000_0102); chk("c2_valid", valid_o, 0);
    cyc(0, 1, 32'hDEAD_BEEF); chk("c3_req", imem_req_o, 0); chk("c3_valid", valid_o, 0);
    cyc(1); chk_req("c4", 64'h8000_0100); chk("c4_valid", valid_o, 0);
    cyc(0, 1, 32'h3333_0100); chk("c5_valid", valid_o, 0);
    cyc(0); chk("c6_pc", pc_o, 64'h8000_0100); chk("c6_instr", instr_o, 32'h3333_0100);
    // Redirect coinciding with the response: no drain.
    do_reset();
    cyc(1); cyc(1);
    cyc(0, 1, 32'hBAD0_0000, 0, 1, 64'h8000_0200); chk("d2_req", imem_req_o, 0); chk("d2_valid", valid_o, 0);
    cyc(0); chk_req("d3", 64'h8000_0200); chk("d3_valid", valid_o, 0);
    cyc(1); chk_req("d4", 64'h8000_0200);
    cyc(0, 1, 32'h4444_0200); chk("d5_valid", valid_o, 0);
    cyc(0); chk("d6_pc", pc_o, 64'h8000_0200); chk("d6_instr", instr_o, 32'h4444_0200);
    // Grant withheld, then redirect without and with grant.
    do_reset();
    cyc(0);
    for (int i = 0; i < 4; i++) begin
      cyc(0); chk_req("e_wait", 64'h8000_0000); chk("e_wait_valid", valid_o, 0);
    end
    cyc(0, 0, 0, 0, 1, 64'h8000_0300); chk_req("e5", 64'h8000_0000);
    cyc(1, 0, 0, 0, 1, 64'h8000_0400); chk_req("e6", 64'h8000_0300);
    cyc(0, 1, 32'hBAD0_0300); chk("e7_req", imem_req_o, 0);
    cyc(0); chk_req("e8", 64'h8000_0400);
    // Redirect from IDLE to the top of the address space; fetch_pc wraps.
    do_reset();
    cyc(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1); chk_req("g1", 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 1, 32'h5555_0000); chk_req("g2", 64'h0);
    cyc(0, 1, 32'h5555_0001); chk("g3_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC); chk("g3_instr", instr_o, 32'h5555_0000);
    cyc(0); chk("g4_pc", pc_o, 64'h0); chk("g4_instr", instr_o, 32'h5555_0001);
    // Reset during WAIT; a late response is ignored.
    do_reset();
    cyc(1); cyc(1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("f_req", imem_req_o, 0); chk("f_valid", valid_o, 0); chk("f_pc", pc_o, RPC); chk("f_instr", instr_o, NOP);
    cyc(0, 1, 32'h6666_0000); chk("f0_req", imem_req_o, 0); chk("f0_valid", valid_o, 0);
    cyc(0, 1, 32'h6666_0004); chk_req("f1", RPC); chk("f1_valid", valid_o, 0);
    cyc(0); chk("f2_valid", valid_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction presented when no valid entry is available.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall_i  input  1  decode cannot accept; hold current output entry.
REQ-006 redirect_i  input  1  control-flow change from EX; flush and refetch.
REQ-007 redirect_pc_i  input  64  new fetch address, valid when redirect_i=1.
REQ-008 imem_req_o  output  1  instruction memory request.
REQ-009 imem_addr_o  output  64  request address, word-aligned.
REQ-010 imem_gnt_i  input  1  request accepted this cycle.
REQ-011 imem_rvalid_i  input  1  response data valid; arrives at least 1 cycle after grant.
REQ-012 imem_rdata_i  input  32  response instruction.
REQ-013 pc_o  output  64  PC of head entry, drives IF/ID pc input.
REQ-014 instr_o  output  32  instruction of head entry, drives IF/ID instr input.
REQ-015 valid_o  output  1  head entry valid, drives IF/ID enable input.

Function
REQ-016 FSM states: IDLE, REQ (req asserted, awaiting gnt), WAIT (one request outstanding), DRAIN (outstanding response to discard).
REQ-017 Maximum one outstanding request; 2-entry FIFO of {pc, instr}.
REQ-018 IDLE->REQ when (FIFO entries + outstanding) < 2, using registered counts only.
REQ-019 REQ: imem_req_o=1, imem_addr_o=fetch_pc; on gnt go WAIT and fetch_pc += 4 (64-bit wrap, no flag).
REQ-020 imem_addr_o and imem_req_o stay stable in REQ until gnt, except on redirect.
REQ-021 WAIT: on rvalid push {request pc, rdata}; same cycle, if space permits, assert req with next fetch_pc (back-to-back, 1 instr/cycle sustained).
REQ-022 valid_o = FIFO not empty; head pops when valid_o=1 and stall_i=0.
REQ-023 FIFO empty: valid_o=0, instr_o=NOP_INSTR, pc_o holds last popped pc.
REQ-024 Push and pop in same cycle allowed at any occupancy; push to full FIFO never occurs (guaranteed by REQ-018).
REQ-025 Latency: rvalid at cycle N -> valid_o=1 at N+1 if FIFO was empty.
REQ-026 Redirect: FIFO flushed, fetch_pc <= {redirect_pc_i[63:2], 2'b00}; next state REQ, or DRAIN if a request is outstanding and rvalid not present this cycle.
REQ-027 DRAIN: req deasserted; next rvalid discarded; then REQ.
REQ-028 Redirect with rvalid in same cycle: response discarded, no DRAIN.
REQ-029 Redirect overrides stall_i; redirect during REQ without gnt re-targets address next cycle.
REQ-030 Redirect with gnt in same cycle: granted request treated as outstanding, enter DRAIN.

Reset
REQ-031 On rst_n=0: state IDLE, fetch_pc=RESET_PC, FIFO empty, outstanding=0, imem_req_o=0, valid_o=0, pc_o=RESET_PC, instr_o=NOP_INSTR.
REQ-032 Reset mid-transaction abandons the outstanding request; rvalid after reset release is ignored until a request has been granted.
REQ-033 First cycle after release: IDLE; imem_req_o=1 with imem_addr_o=RESET_PC on the second cycle.

Structure
REQ-034 RESET_PC, NOP_INSTR and FSM state encoding live in the shared defines package.
REQ-035 FIFO implemented as sub-module fetch_fifo (2-entry, 96-bit, push/pop/flush/count).

Verification
REQ-036 Reset then gnt immediate, rvalid +1, stall_i=0 -> addresses 8000_0000, 8000_0004, 8000_0008 in consecutive cycles; valid_o continuous after first.
REQ-037 stall_i=1 for 5 cycles -> FIFO fills to 2, imem_req_o drops, pc_o/instr_o held; release -> entries emitted in order.
REQ-038 redirect_i with redirect_pc_i=8000_0102 while outstanding -> DRAIN, stale rdata discarded, next addr 8000_0100, valid_o=0 until new data.
REQ-039 redirect_i and imem_rvalid_i same cycle -> data never appears on valid_o, next req addr = redirect target.
REQ-040 gnt held low 4 cycles -> imem_addr_o stable 8000_0000, no valid_o.
REQ-041 rst_n pulsed low during WAIT -> all outputs at reset values; late rvalid ignored.
